// File: rtl/fifo_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : fifo_traffic_gen
// Brief    : Drives a fill / drain / mixed / flush traffic sequence into a
//            FIFO and checks read-back data against an incrementing reference.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_traffic_gen #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    BURST_LEN   = 16,
    parameter int                    MIX_CYCLES  = 32,
    parameter int                    START_DELAY = 4,
    parameter logic [DATA_WIDTH-1:0] SEED        = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           error_cnt,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_DRAIN = 3'd2,
        S_MIXED = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Last phase-counter value before leaving a timed state (counter starts at 0)
    localparam logic [31:0] c_idle_last  = (START_DELAY > 1) ? 32'(START_DELAY - 1) : 32'd0;
    localparam logic [31:0] c_burst_last = (BURST_LEN > 1)   ? 32'(BURST_LEN - 1)   : 32'd0;
    localparam logic [31:0] c_mix_last   = (MIX_CYCLES > 1)  ? 32'(MIX_CYCLES - 1)  : 32'd0;
    localparam logic [15:0] c_cnt_max    = 16'hFFFF;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_phase_cnt;
    logic [31:0]           r_burst_cnt;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_exp_data;
    logic                  r_pend;
    logic [15:0]           r_wr_cnt;
    logic [15:0]           r_rd_cnt;
    logic [15:0]           r_err_cnt;
    logic                  w_wr_en;
    logic                  w_rd_en;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_phase_cnt >= c_idle_last) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                w_wr_en = !fifo_full;
                // A non-full cycle at the last burst slot always carries the final write
                if (fifo_full || (r_burst_cnt >= c_burst_last)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_rd_en = !fifo_empty;
                if (fifo_empty && !r_pend) w_state_nxt = S_MIXED;
            end
            S_MIXED: begin
                w_wr_en = !fifo_full;
                w_rd_en = !fifo_empty;
                if (r_phase_cnt >= c_mix_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_rd_en = !fifo_empty;
                if (fifo_empty && !r_pend) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= 32'd0;
            r_burst_cnt <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase_cnt <= (w_state_nxt != r_state) ? 32'd0 : r_phase_cnt + 32'd1;
            if (w_wr_en && (r_state == S_FILL)) r_burst_cnt <= r_burst_cnt + 32'd1;
        end
    end

    // Read data arrives one clock after the accepted strobe; r_pend marks that slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_data  <= SEED;
            r_exp_data <= SEED;
            r_pend     <= 1'b0;
            r_wr_cnt   <= 16'd0;
            r_rd_cnt   <= 16'd0;
            r_err_cnt  <= 16'd0;
        end else begin
            r_pend <= w_rd_en;
            if (w_wr_en) begin
                r_wr_data <= r_wr_data + DATA_WIDTH'(1);
                if (r_wr_cnt != c_cnt_max) r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (r_pend) begin
                r_exp_data <= r_exp_data + DATA_WIDTH'(1);
                if (r_rd_cnt != c_cnt_max) r_rd_cnt <= r_rd_cnt + 16'd1;
                if ((rd_data != r_exp_data) && (r_err_cnt != c_cnt_max)) r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign wr_en     = w_wr_en;
    assign rd_en     = w_rd_en;
    assign wr_data   = r_wr_data;
    assign wr_cnt    = r_wr_cnt;
    assign rd_cnt    = r_rd_cnt;
    assign error_cnt = r_err_cnt;
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_traffic_gen
// Brief    : Scoreboard bench for fifo_traffic_gen with a behavioural FIFO per DUT
//            (instance 0: default SEED, scenario-configured; instance 1: SEED=8'hFE).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_traffic_gen;

    localparam int c_TIMEOUT = 3000;

    typedef struct packed {
        int fill;
        int win_wr;
        int win_rd;
        int mix_len;
    } end_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  fifo_full;
    logic [1:0]  fifo_empty;
    logic [1:0]  wr_en;
    logic [1:0]  rd_en;
    logic [1:0]  done;
    logic [7:0]  wr_data   [2];
    logic [7:0]  rd_data   [2];
    logic [15:0] wr_cnt    [2];
    logic [15:0] rd_cnt    [2];
    logic [15:0] error_cnt [2];

    always #5 clk = ~clk;

    fifo_traffic_gen u_dut (
        .clk(clk), .reset(reset), .fifo_full(fifo_full[0]), .fifo_empty(fifo_empty[0]),
        .wr_en(wr_en[0]), .wr_data(wr_data[0]), .rd_en(rd_en[0]), .rd_data(rd_data[0]),
        .wr_cnt(wr_cnt[0]), .rd_cnt(rd_cnt[0]), .error_cnt(error_cnt[0]), .done(done[0])
    );

    fifo_traffic_gen #(.SEED(8'hFE)) u_dut_seed (
        .clk(clk), .reset(reset), .fifo_full(fifo_full[1]), .fifo_empty(fifo_empty[1]),
        .wr_en(wr_en[1]), .wr_data(wr_data[1]), .rd_en(rd_en[1]), .rd_data(rd_data[1]),
        .wr_cnt(wr_cnt[1]), .rd_cnt(rd_cnt[1]), .error_cnt(error_cnt[1]), .done(done[1])
    );

    // ---------------- FIFO models ----------------
    logic [7:0] mem [2][16];
    logic [4:0] occ [2];
    logic [3:0] wp  [2];
    logic [3:0] rp  [2];
    int         nrd [2];
    int         cap0        = 16;
    int         corrupt_idx = -1;
    logic       force_en    = 1'b0;
    logic       force_reg;

    // Monitor-owned phase tracking, read by the model to place the forced-full window
    logic mix_on    = 1'b0;
    int   mix_k     = 0;

    assign fifo_full[0]  = (int'(occ[0]) == cap0) || force_reg;
    assign fifo_full[1]  = (occ[1] == 5'd16);
    assign fifo_empty[0] = (occ[0] == 5'd0);
    assign fifo_empty[1] = (occ[1] == 5'd0);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            force_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                occ[i]     <= 5'd0;
                wp[i]      <= 4'd0;
                rp[i]      <= 4'd0;
                nrd[i]     <= 0;
                rd_data[i] <= 8'h00;
            end
        end else begin
            // Full forced during MIXED clocks 5..14 (ten clocks)
            force_reg <= force_en && mix_on && (mix_k >= 4) && (mix_k <= 13);
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i]) begin
                    mem[i][wp[i]] <= wr_data[i];
                    wp[i]         <= wp[i] + 4'd1;
                end
                if (rd_en[i]) begin
                    rd_data[i] <= ((i == 0) && (nrd[i] == corrupt_idx)) ? 8'hFF : mem[i][rp[i]];
                    rp[i]      <= rp[i] + 4'd1;
                    nrd[i]     <= nrd[i] + 1;
                end
                occ[i] <= occ[i] + {4'd0, wr_en[i]} - {4'd0, rd_en[i]};
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_wr_q0 [$];
    logic [7:0]  exp_wr_q1 [$];
    logic [47:0] fin_q0    [$];
    logic [47:0] fin_q1    [$];
    end_t        end_q     [$];
    int          scen_req      = 0;
    int          stim_timeouts = 0;

    int   checks       = 0;
    int   failures     = 0;
    int   scen_done_id = 0;
    int   idle_clks    = 0;
    logic first_wr     = 1'b0;
    logic seen_rd      = 1'b0;
    int   fill_wr      = 0;
    int   win_wr       = 0;
    int   win_rd       = 0;
    int   last_wr_k    = 0;
    logic [1:0] done_seen = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic chk_wr(input int inst, input logic [7:0] act);
        logic [7:0] e;
        if (inst == 0 ? (exp_wr_q0.size() == 0) : (exp_wr_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL wr_data%0d: got 0x%0h, expected no further write", inst, act);
        end else begin
            e = (inst == 0) ? exp_wr_q0.pop_front() : exp_wr_q1.pop_front();
            chk($sformatf("wr_data%0d", inst), 64'(act), 64'(e));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_outs0", 64'({wr_en[0], rd_en[0], done[0], wr_data[0], wr_cnt[0], rd_cnt[0], error_cnt[0]}),
                64'({3'b000, 8'h00, 48'h0}));
            chk("reset_outs1", 64'({wr_en[1], rd_en[1], done[1], wr_data[1], wr_cnt[1], rd_cnt[1], error_cnt[1]}),
                64'({3'b000, 8'hFE, 48'h0}));
            idle_clks = 0;  first_wr  = 1'b0; seen_rd = 1'b0; mix_on = 1'b0; mix_k = 0;
            fill_wr   = 0;  win_wr    = 0;    win_rd  = 0;    last_wr_k = 0;  done_seen = 2'b00;
        end else begin
            if (!first_wr) begin
                idle_clks++;
                if (wr_en[0]) begin
                    chk("idle_len", 64'(idle_clks), 64'd4);
                    first_wr = 1'b1;
                end
            end
            if (mix_on) mix_k++;
            else if (seen_rd && wr_en[0]) begin
                mix_on = 1'b1;
                mix_k  = 1;
            end
            if (wr_en[0] && mix_on) last_wr_k = mix_k;
            if (wr_en[0] && !seen_rd) fill_wr++;
            if (force_reg && wr_en[0]) win_wr++;
            if (force_reg && rd_en[0]) win_rd++;
            if (rd_en[0]) seen_rd = 1'b1;
            if (wr_en[0]) chk_wr(0, wr_data[0]);
            if (wr_en[1]) chk_wr(1, wr_data[1]);
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    chk($sformatf("done_strobes%0d", i), 64'({wr_en[i], rd_en[i]}), 64'd0);
                    if (!done_seen[i]) begin
                        done_seen[i] = 1'b1;
                        if (i == 0 && fin_q0.size() != 0)
                            chk("final_counts0", 64'({wr_cnt[0], rd_cnt[0], error_cnt[0]}), 64'(fin_q0.pop_front()));
                        else if (i == 1 && fin_q1.size() != 0)
                            chk("final_counts1", 64'({wr_cnt[1], rd_cnt[1], error_cnt[1]}), 64'(fin_q1.pop_front()));
                    end
                end
            end
            if (scen_req != scen_done_id) begin
                end_t e;
                e = (end_q.size() != 0) ? end_q.pop_front() : end_t'{-1, -1, -1, -1};
                chk("done_both",   64'(done_seen), 64'(2'b11));
                chk("fill_writes", 64'(fill_wr),   64'(e.fill));
                chk("mixed_len",   64'(last_wr_k), 64'(e.mix_len));
                chk("win_writes",  64'(win_wr),    64'(e.win_wr));
                chk("win_reads",   64'(win_rd),    64'(e.win_rd));
                chk("wr_q0_left",  64'(exp_wr_q0.size()), 64'd0);
                chk("wr_q1_left",  64'(exp_wr_q1.size()), 64'd0);
                chk("stim_timeouts", 64'(stim_timeouts), 64'd0);
                scen_done_id = scen_req;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_run(input int cap, input int corrupt, input logic frc,
                             input int n_wr, input int n_rd, input int n_err);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        cap0        = cap;
        corrupt_idx = corrupt;
        force_en    = frc;
        exp_wr_q0.delete();
        exp_wr_q1.delete();
        fin_q0.delete();
        fin_q1.delete();
        for (int k = 0; k < n_wr; k++) exp_wr_q0.push_back(8'(k));
        for (int k = 0; k < 48; k++)   exp_wr_q1.push_back(8'(8'hFE + k));
        fin_q0.push_back({16'(n_wr), 16'(n_rd), 16'(n_err)});
        fin_q1.push_back({16'd48, 16'd48, 16'd0});
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic run_scen(input int cap, input int corrupt, input logic frc,
                            input int n_wr, input int n_rd, input int n_err,
                            input int n_fill, input int wwr, input int wrd);
        int c;
        start_run(cap, corrupt, frc, n_wr, n_rd, n_err);
        end_q.push_back(end_t'{n_fill, wwr, wrd, 32});
        c = 0;
        while (c < c_TIMEOUT && done != 2'b11) begin
            @(negedge clk);
            c++;
        end
        if (c >= c_TIMEOUT) stim_timeouts++;
        repeat (3) @(negedge clk);
        #1;
        scen_req++;
        c = 0;
        while (c < 10 && scen_done_id != scen_req) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        int c;
        // cap, corrupt, force, wr, rd, err, fill, win_wr, win_rd
        run_scen(16, -1, 1'b0, 48, 48, 0, 16, 0, 0);   // ideal 16-deep
        run_scen(5,  -1, 1'b0, 37, 37, 0,  5, 0, 0);   // full after 5 entries
        run_scen(16,  2, 1'b0, 48, 48, 1, 16, 0, 0);   // third read corrupted
        run_scen(16, -1, 1'b1, 38, 38, 0, 16, 0, 1);   // full forced 10 clocks in MIXED

        // Abort mid-MIXED, then a complete clean run from scratch
        start_run(16, -1, 1'b0, 48, 48, 0);
        c = 0;
        while (c < c_TIMEOUT && !(mix_on && mix_k >= 10)) begin
            @(posedge clk);
            c++;
        end
        if (c >= c_TIMEOUT) stim_timeouts++;
        run_scen(16, -1, 1'b0, 48, 48, 0, 16, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
